// File: rtl/i2c_scl_gen_if.sv
// Bus-side signals of the I2C SCL generator; the controller holds master, the generator holds slave.
// en is a level request, not a handshake: while high, periods are started back-to-back.
interface i2c_scl_gen_if;
    logic       en;
    logic       fast_mode;
    logic       scl_in;
    logic       scl_t;
    logic       fall_stb;
    logic       low_mid_stb;
    logic       rise_stb;
    logic       high_mid_stb;
    logic       busy;
    logic       stretch;
    logic       timeout_err;
    logic [2:0] state_dbg;

    modport master (
        output en, fast_mode, scl_in,
        input  scl_t, fall_stb, low_mid_stb, rise_stb, high_mid_stb,
        input  busy, stretch, timeout_err, state_dbg
    );

    modport slave (
        input  en, fast_mode, scl_in,
        output scl_t, fall_stb, low_mid_stb, rise_stb, high_mid_stb,
        output busy, stretch, timeout_err, state_dbg
    );
endinterface

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: 100/400 kHz, start/stop gating, clock-stretch detection, quarter-phase strobes.
// Optional stretch timeout is compiled in when I2C_SCL_STRETCH_TIMEOUT_EN is defined.
module i2c_scl_gen #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int STD_SCL_HZ     = 100_000,
    parameter int FAST_SCL_HZ    = 400_000,
    parameter int CNT_W          = 12,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic          CLK,
    input  logic          rst,
    i2c_scl_gen_if.slave  bus
);
    localparam int Q_STD  = CLK_FREQ_HZ / (4 * STD_SCL_HZ);
    localparam int Q_FAST = CLK_FREQ_HZ / (4 * FAST_SCL_HZ);
    localparam int Q_MAX  = (1 << CNT_W) - 1;

    if (Q_STD < 8 || Q_FAST < 8 || Q_STD > Q_MAX || Q_FAST > Q_MAX || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("i2c_scl_gen: quarter period out of range for CNT_W, or TIMEOUT_CYCLES too small");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOW_A  = 3'd1,
        S_LOW_B  = 3'd2,
        S_WAIT_H = 3'd3,
        S_HIGH_A = 3'd4,
        S_HIGH_B = 3'd5
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_scl_t;
    logic             r_fall_stb;
    logic             r_low_mid_stb;
    logic             r_rise_stb;
    logic             r_high_mid_stb;
    logic             r_busy;
    logic             r_stretch;
    logic             r_timeout_err;

    logic             w_scl_s;
    logic             w_cnt_done;
    logic             w_rise_ok;
    logic             w_start;
    logic             w_to_fire;
    logic [CNT_W-1:0] w_q_sel;

    assign w_scl_s    = r_sync[1];
    assign w_cnt_done = (r_cnt == '0);
    assign w_q_sel    = bus.fast_mode ? CNT_W'(Q_FAST) : CNT_W'(Q_STD);
    // In WAIT_H r_cnt counts up and saturates at 3, so the release+sync minimum holds even on a stuck-high line.
    assign w_rise_ok  = w_scl_s && (r_cnt == CNT_W'(3));

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_armed;

    assign w_to_fire = (r_state == S_WAIT_H) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_start   = bus.en && r_armed;

    // After a timeout, en must be seen low once before a new period may start.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_armed  <= 1'b1;
        end else begin
            r_to_cnt <= (r_state == S_WAIT_H) ? r_to_cnt + TO_W'(1) : '0;
            if (w_to_fire && !w_rise_ok)
                r_armed <= 1'b0;
            else if (!bus.en)
                r_armed <= 1'b1;
        end
    end
`else
    assign w_to_fire = 1'b0;
    assign w_start   = bus.en;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sync         <= 2'b11;
            r_q            <= CNT_W'(Q_STD);
            r_cnt          <= '0;
            r_scl_t        <= 1'b1;
            r_fall_stb     <= 1'b0;
            r_low_mid_stb  <= 1'b0;
            r_rise_stb     <= 1'b0;
            r_high_mid_stb <= 1'b0;
            r_busy         <= 1'b0;
            r_stretch      <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sync         <= {r_sync[0], bus.scl_in};
            r_fall_stb     <= 1'b0;
            r_low_mid_stb  <= 1'b0;
            r_rise_stb     <= 1'b0;
            r_high_mid_stb <= 1'b0;
            r_timeout_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_LOW_A;
                        r_q        <= w_q_sel;
                        r_cnt      <= w_q_sel - CNT_W'(1);
                        r_scl_t    <= 1'b0;
                        r_fall_stb <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOW_A: begin
                    if (w_cnt_done) begin
                        r_state       <= S_LOW_B;
                        r_cnt         <= r_q - CNT_W'(1);
                        r_low_mid_stb <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_LOW_B: begin
                    if (w_cnt_done) begin
                        r_state <= S_WAIT_H;
                        r_cnt   <= CNT_W'(1);
                        r_scl_t <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_H: begin
                    if (w_rise_ok) begin
                        r_state    <= S_HIGH_A;
                        r_cnt      <= r_q - CNT_W'(4);
                        r_rise_stb <= 1'b1;
                        r_stretch  <= 1'b0;
                    end else if (w_to_fire) begin
                        r_state       <= S_IDLE;
                        r_cnt         <= '0;
                        r_busy        <= 1'b0;
                        r_stretch     <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        if (r_cnt != CNT_W'(3))
                            r_cnt <= r_cnt + CNT_W'(1);
                        r_stretch <= (r_cnt == CNT_W'(3));
                    end
                end
                // HIGH_A is Q-3 long so that WAIT_H's 3-cycle minimum keeps the high phase at 2Q.
                S_HIGH_A: begin
                    if (w_cnt_done) begin
                        r_state        <= S_HIGH_B;
                        r_cnt          <= r_q - CNT_W'(1);
                        r_high_mid_stb <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_HIGH_B: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (bus.en) begin
                        r_state    <= S_LOW_A;
                        r_q        <= w_q_sel;
                        r_cnt      <= w_q_sel - CNT_W'(1);
                        r_scl_t    <= 1'b0;
                        r_fall_stb <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_scl_t <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scl_t        = r_scl_t;
    assign bus.fall_stb     = r_fall_stb;
    assign bus.low_mid_stb  = r_low_mid_stb;
    assign bus.rise_stb     = r_rise_stb;
    assign bus.high_mid_stb = r_high_mid_stb;
    assign bus.busy         = r_busy;
    assign bus.stretch      = r_stretch;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: std/fast periods, rate change, stretch, en drop, reset, stuck-low line.
// SCL is looped back through an open-drain model; hold_low emulates a slave stretching the clock.
module tb_i2c_scl_gen;
    logic CLK;
    logic rst;
    logic hold_low;

    i2c_scl_gen_if ifc ();

    i2c_scl_gen #(.TIMEOUT_CYCLES(1000)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (ifc.slave)
    );

    assign ifc.scl_in = ifc.scl_t & ~hold_low;

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // drivers
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [3:0] stb();
        return {ifc.fall_stb, ifc.low_mid_stb, ifc.rise_stb, ifc.high_mid_stb};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".scl_t"}, ifc.scl_t, 1);
        check({tag, ".busy"}, ifc.busy, 0);
        check({tag, ".stb"}, stb(), 0);
        check({tag, ".stretch"}, ifc.stretch, 0);
        check({tag, ".toerr"}, ifc.timeout_err, 0);
    endtask

    // Starts on a fall_stb cycle (offset 0); ends on the next fall_stb or on the first idle cycle.
    task automatic measure(input string tag, input int e_lo, input int e_hi, input int e_lm,
                           input int e_ri, input int e_hm, input int e_per,
                           input int fast_at, input logic fast_val, input int drop_at);
        int lo, hi, lm, ri, hm, per, nstb, multi;
        lo = 0; hi = 0; lm = -1; ri = -1; hm = -1; per = -1; nstb = 0; multi = 0;
        exp_q.push_back(e_lo);  exp_q.push_back(e_hi);  exp_q.push_back(e_lm);
        exp_q.push_back(e_ri);  exp_q.push_back(e_hm);  exp_q.push_back(e_per);
        exp_q.push_back(4);     exp_q.push_back(0);
        for (int k = 0; k < 2000; k++) begin
            if (k > 0 && (ifc.fall_stb || !ifc.busy)) begin
                per = k;
                break;
            end
            if (k == fast_at) ifc.fast_mode = fast_val;
            if (k == drop_at) ifc.en = 1'b0;
            if (ifc.scl_t) hi++; else lo++;
            if (ifc.low_mid_stb && lm < 0) lm = k;
            if (ifc.rise_stb && ri < 0) ri = k;
            if (ifc.high_mid_stb && hm < 0) hm = k;
            nstb += $countones(stb());
            if ($countones(stb()) > 1) multi++;
            step();
        end
        check({tag, ".low"}, lo, exp_q.pop_front());
        check({tag, ".high"}, hi, exp_q.pop_front());
        check({tag, ".low_mid"}, lm, exp_q.pop_front());
        check({tag, ".rise"}, ri, exp_q.pop_front());
        check({tag, ".high_mid"}, hm, exp_q.pop_front());
        check({tag, ".period"}, per, exp_q.pop_front());
        check({tag, ".n_stb"}, nstb, exp_q.pop_front());
        check({tag, ".multi"}, multi, exp_q.pop_front());
    endtask

    task automatic wait_release(input string tag);
        int got;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            if (ifc.scl_t) begin
                got = 1;
                break;
            end
            step();
        end
        check({tag, ".release_seen"}, got, 1);
    endtask

    int first_st, ri, hm, per, nstb, nfall, nlow, nto, first_to;

    initial begin
        rst = 1'b1;
        hold_low = 1'b0;
        ifc.en = 1'b0;
        ifc.fast_mode = 1'b0;
        steps(3);
        check_quiet("reset");
        check("reset.state", ifc.state_dbg, 0);
        rst = 1'b0;
        step();
        check("idle.busy", ifc.busy, 0);

        // standard rate, back-to-back periods, then a mid-low switch to fast
        ifc.en = 1'b1;
        step();
        check("start.fall", ifc.fall_stb, 1);
        check("start.scl_t", ifc.scl_t, 0);
        check("start.busy", ifc.busy, 1);
        measure("std1", 250, 250, 125, 253, 375, 500, -1, 1'b0, -1);
        measure("std2", 250, 250, 125, 253, 375, 500, 50, 1'b1, -1);
        measure("fast1", 62, 62, 31, 65, 93, 124, -1, 1'b0, -1);
        measure("fast2", 62, 62, 31, 65, 93, 124, 10, 1'b0, -1);
        measure("std_drop", 250, 250, 125, 253, 375, 500, -1, 1'b0, 60);
        nfall = 0; nlow = 0;
        for (int k = 0; k < 600; k++) begin
            if (ifc.fall_stb) nfall++;
            if (!ifc.scl_t || ifc.busy) nlow++;
            step();
        end
        check("drop.no_fall", nfall, 0);
        check("drop.idle_high", nlow, 0);

        // slave stretches SCL for 1000 cycles after release
        ifc.en = 1'b1;
        step();
        check("st.fall", ifc.fall_stb, 1);
        hold_low = 1'b1;
        wait_release("st");
        first_st = -1; ri = -1; nstb = 0;
        for (int k = 0; k < 1200; k++) begin
            if (k == 1000) hold_low = 1'b0;
            if (ifc.stretch && first_st < 0) first_st = k;
            if (ifc.rise_stb) begin
                ri = k;
                break;
            end
            nstb += $countones(stb());
            step();
        end
        check("st.first_stretch", first_st, 3);
        check("st.rise", ri, 1003);
        check("st.no_stb", nstb, 0);
        check("st.stretch_clr", ifc.stretch, 0);
        hm = -1; per = -1;
        for (int k = 0; k < 600; k++) begin
            if (k > 0 && ifc.fall_stb) begin
                per = k;
                break;
            end
            if (ifc.high_mid_stb && hm < 0) hm = k;
            step();
        end
        check("st.high_mid", hm, 122);
        check("st.high_len", per, 247);

        // reset mid-HIGH_A, then mid-LOW_B
        steps(260);
        check("rstA.state", ifc.state_dbg, 4);
        rst = 1'b1;
        step();
        check_quiet("rstA");
        rst = 1'b0;
        step();
        check("rstA.fall", ifc.fall_stb, 1);
        check("rstA.scl_t", ifc.scl_t, 0);
        steps(180);
        check("rstB.state", ifc.state_dbg, 2);
        rst = 1'b1;
        step();
        check_quiet("rstB");
        rst = 1'b0;
        ifc.en = 1'b0;
        step();
        check("rstB.idle", ifc.busy, 0);

        // SCL stuck low after release
        ifc.en = 1'b1;
        hold_low = 1'b1;
        step();
        check("stuck.fall", ifc.fall_stb, 1);
        wait_release("stuck");
        nto = 0; first_to = -1; nfall = 0;
        for (int k = 0; k < 1100; k++) begin
            if (ifc.timeout_err) begin
                nto++;
                if (first_to < 0) first_to = k;
            end
            if (ifc.fall_stb) nfall++;
            step();
        end
        check("stuck.no_fall", nfall, 0);
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
        check("to.pulses", nto, 1);
        check("to.at", first_to, 1000);
        check_quiet("to.idle");
        hold_low = 1'b0;
        ifc.en = 1'b0;
        step();
        ifc.en = 1'b1;
        step();
        check("to.restart", ifc.fall_stb, 1);
`else
        check("stuck.no_toerr", nto, 0);
        check("stuck.state", ifc.state_dbg, 3);
        check("stuck.stretch", ifc.stretch, 1);
        check("stuck.busy", ifc.busy, 1);
        check("stuck.scl_t", ifc.scl_t, 1);
`endif
        hold_low = 1'b0;
        ifc.en = 1'b0;
        per = -1;
        for (int k = 0; k < 600; k++) begin
            if (!ifc.busy) begin
                per = k;
                break;
            end
            step();
        end
        check("end.idle_reached", (per >= 0), 1);
        check("end.scl_t", ifc.scl_t, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
